// File: rtl/snake_tile_map.sv
// Tile-level snake model: segment ring buffer, per-tile image-code map and raster read port.
// Define SNAKE_WRAP_EN to wrap the head across grid edges instead of treating the edge as a collision.
module snake_tile_map #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int MAX_LEN = 64,
    parameter int INIT_X  = 10,
    parameter int INIT_Y  = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_step,
    input  logic [1:0] i_dir,
    input  logic       i_grow,
    input  logic [9:0] i_pos_x,
    input  logic [9:0] i_pos_y,
    output logic [3:0] o_snake_image,
    output logic       o_hit,
    output logic [9:0] o_pos_x,
    output logic [9:0] o_pos_y,
    output logic       o_busy,
    output logic       o_dead,
    output logic       o_collide,
    output logic [6:0] o_length,
    output logic [5:0] o_head_x,
    output logic [4:0] o_head_y
);

    // state | meaning
    // INIT  | clear one map entry per cycle
    // SEED  | write the initial tail, body and head tiles
    // IDLE  | wait for an accepted step
    // RD    | compute new head tile, read its map entry
    // CHK   | collision decision
    // WH    | write new head code
    // WN    | rewrite old head as straight/turn
    // WT    | clear old tail tile (non-grow)
    // WS    | write new tail code, commit buffer

    localparam int PW = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 2;
    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;
    localparam logic [5:0] X_MAX   = 6'(GRID_W - 1);
    localparam logic [4:0] Y_MAX   = 5'(GRID_H - 1);
    localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
    localparam logic [9:0] PIX_W   = 10'(GRID_W * 16);
    localparam logic [9:0] PIX_H   = 10'(GRID_H * 16);

    typedef enum logic [3:0] {
        S_INIT, S_SEED, S_IDLE, S_RD, S_CHK, S_WH, S_WN, S_WT, S_WS
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     init_x_q, init_x_d;
    logic [4:0]     init_y_q, init_y_d;
    logic [1:0]     seed_q, seed_d;
    logic [1:0]     cur_dir_q, cur_dir_d;
    logic           grow_q, grow_d;
    logic [5:0]     nh_x_q, nh_x_d;
    logic [4:0]     nh_y_q, nh_y_d;
    logic           oob_q, oob_d;
    logic [PW-1:0]  head_ptr_q, head_ptr_d;
    logic [PW-1:0]  tail_ptr_q, tail_ptr_d;
    logic [6:0]     length_q, length_d;
    logic [5:0]     head_x_q, head_x_d;
    logic [4:0]     head_y_q, head_y_d;
    logic           dead_q, dead_d;
    logic           collide_q, collide_d;
    logic [9:0]     pos_x_q, pos_x_d;
    logic [9:0]     pos_y_q, pos_y_d;
    logic           in_range_q, in_range_d;

    logic [5:0]     seg_x_q   [MAX_LEN];
    logic [4:0]     seg_y_q   [MAX_LEN];
    logic [1:0]     seg_dir_q [MAX_LEN];
    logic           seg_we;
    logic [PW-1:0]  seg_wa;
    logic [5:0]     seg_wx;
    logic [4:0]     seg_wy;
    logic [1:0]     seg_wdir;

    logic [4:0]     map_mem [2048];
    logic           map_we;
    logic [10:0]    map_addr;
    logic [4:0]     map_wdata;
    logic           valid_a_q;
    logic [4:0]     entry_b_q;
    logic [10:0]    raster_addr;

    logic [5:0]     nx;
    logic [4:0]     ny;
    logic           at_edge;
    logic           noob;
    logic [PW-1:0]  t1_ptr, t2_ptr;
    logic [5:0]     tail_x;
    logic [4:0]     tail_y;
    logic           nh_on_tail;
    logic           collide_now;
    logic           commit;
    logic [5:0]     seed_x;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [1:0] opp(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

    // a = side the segment was entered from, b = side it leaves through
    function automatic logic [3:0] link_code(input logic [1:0] a, input logic [1:0] b);
        logic has_up, has_down, has_right;
        has_up    = (a == D_UP)    || (b == D_UP);
        has_down  = (a == D_DOWN)  || (b == D_DOWN);
        has_right = (a == D_RIGHT) || (b == D_RIGHT);
        if (a == opp(b))            return a[1] ? 4'd5 : 4'd4;
        else if (has_up && has_right)   return 4'd6;
        else if (has_down && has_right) return 4'd7;
        else if (has_up)                return 4'd8;
        else                            return 4'd9;
    endfunction

    always_comb begin
        nx      = head_x_q;
        ny      = head_y_q;
        at_edge = 1'b0;
        unique case (cur_dir_q)
            D_UP: begin
                at_edge = (head_y_q == 5'd0);
                ny      = at_edge ? Y_MAX : head_y_q - 5'd1;
            end
            D_DOWN: begin
                at_edge = (head_y_q == Y_MAX);
                ny      = at_edge ? 5'd0 : head_y_q + 5'd1;
            end
            D_LEFT: begin
                at_edge = (head_x_q == 6'd0);
                nx      = at_edge ? X_MAX : head_x_q - 6'd1;
            end
            default: begin
                at_edge = (head_x_q == X_MAX);
                nx      = at_edge ? 6'd0 : head_x_q + 6'd1;
            end
        endcase
`ifdef SNAKE_WRAP_EN
        noob = 1'b0;
`else
        noob = at_edge;
`endif
    end

    assign t1_ptr      = ptr_inc(tail_ptr_q);
    assign t2_ptr      = ptr_inc(t1_ptr);
    assign tail_x      = seg_x_q[tail_ptr_q];
    assign tail_y      = seg_y_q[tail_ptr_q];
    assign nh_on_tail  = (nh_x_q == tail_x) && (nh_y_q == tail_y);
    // The tail tile is free to enter only when the tail moves away this step
    assign collide_now = oob_q || (valid_a_q && !(nh_on_tail && !grow_q));
    assign seed_x      = 6'(INIT_X - 2) + {4'd0, seed_q};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_INIT;
            init_x_q   <= '0;
            init_y_q   <= '0;
            seed_q     <= '0;
            cur_dir_q  <= D_RIGHT;
            grow_q     <= 1'b0;
            nh_x_q     <= '0;
            nh_y_q     <= '0;
            oob_q      <= 1'b0;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            length_q   <= '0;
            head_x_q   <= '0;
            head_y_q   <= '0;
            dead_q     <= 1'b0;
            collide_q  <= 1'b0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            in_range_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_x_q   <= init_x_d;
            init_y_q   <= init_y_d;
            seed_q     <= seed_d;
            cur_dir_q  <= cur_dir_d;
            grow_q     <= grow_d;
            nh_x_q     <= nh_x_d;
            nh_y_q     <= nh_y_d;
            oob_q      <= oob_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            length_q   <= length_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            dead_q     <= dead_d;
            collide_q  <= collide_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            in_range_q <= in_range_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT: if (init_x_q == X_MAX && init_y_q == Y_MAX) state_d = S_SEED;
            S_SEED: if (seed_q == 2'd2) state_d = S_IDLE;
            S_IDLE: if (i_step && !dead_q) state_d = S_RD;
            S_RD:   state_d = S_CHK;
            S_CHK:  state_d = collide_now ? S_IDLE : S_WH;
            S_WH:   state_d = S_WN;
            S_WN:   state_d = S_WT;
            S_WT:   state_d = grow_q ? S_IDLE : S_WS;
            S_WS:   state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        init_x_d   = init_x_q;
        init_y_d   = init_y_q;
        seed_d     = seed_q;
        cur_dir_d  = cur_dir_q;
        grow_d     = grow_q;
        nh_x_d     = nh_x_q;
        nh_y_d     = nh_y_q;
        oob_d      = oob_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        length_d   = length_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        dead_d     = dead_q;
        collide_d  = 1'b0;
        map_we     = 1'b0;
        map_addr   = '0;
        map_wdata  = '0;
        seg_we     = 1'b0;
        seg_wa     = '0;
        seg_wx     = '0;
        seg_wy     = '0;
        seg_wdir   = '0;
        commit     = 1'b0;
        unique case (state_q)
            S_INIT: begin
                map_we   = 1'b1;
                map_addr = {init_y_q, init_x_q};
                if (init_x_q == X_MAX) begin
                    init_x_d = '0;
                    init_y_d = init_y_q + 5'd1;
                end else begin
                    init_x_d = init_x_q + 6'd1;
                end
            end
            S_SEED: begin
                map_we    = 1'b1;
                map_addr  = {5'(INIT_Y), seed_x};
                map_wdata = (seed_q == 2'd0) ? 5'h1D : (seed_q == 2'd1) ? 5'h15 : 5'h13;
                seg_we    = 1'b1;
                seg_wa    = PW'(seed_q);
                seg_wx    = seed_x;
                seg_wy    = 5'(INIT_Y);
                seg_wdir  = D_RIGHT;
                seed_d    = seed_q + 2'd1;
                if (seed_q == 2'd2) begin
                    length_d   = 7'd3;
                    cur_dir_d  = D_RIGHT;
                    head_x_d   = 6'(INIT_X);
                    head_y_d   = 5'(INIT_Y);
                    tail_ptr_d = '0;
                    head_ptr_d = PW'(2);
                end
            end
            S_IDLE: begin
                if (i_step && !dead_q) begin
                    cur_dir_d = (i_dir == opp(cur_dir_q)) ? cur_dir_q : i_dir;
                    grow_d    = i_grow && (length_q < LEN_MAX);
                end
            end
            S_RD: begin
                map_addr = {ny, nx};
                nh_x_d   = nx;
                nh_y_d   = ny;
                oob_d    = noob;
            end
            S_CHK: begin
                if (collide_now) begin
                    dead_d    = 1'b1;
                    collide_d = 1'b1;
                end
            end
            S_WH: begin
                map_we    = 1'b1;
                map_addr  = {nh_y_q, nh_x_q};
                map_wdata = {3'b100, cur_dir_q};
            end
            S_WN: begin
                map_we    = 1'b1;
                map_addr  = {head_y_q, head_x_q};
                map_wdata = {1'b1, link_code(opp(seg_dir_q[head_ptr_q]), cur_dir_q)};
            end
            S_WT: begin
                if (!grow_q && !nh_on_tail) begin
                    map_we   = 1'b1;
                    map_addr = {tail_y, tail_x};
                end
                commit = grow_q;
            end
            S_WS: begin
                map_we    = 1'b1;
                map_addr  = {seg_y_q[t1_ptr], seg_x_q[t1_ptr]};
                map_wdata = {1'b1, 4'd10 + {2'b00, seg_dir_q[t2_ptr]}};
                commit    = 1'b1;
            end
            default: ;
        endcase
        // Buffer and pointers change only once the map update is complete
        if (commit) begin
            seg_we     = 1'b1;
            seg_wa     = ptr_inc(head_ptr_q);
            seg_wx     = nh_x_q;
            seg_wy     = nh_y_q;
            seg_wdir   = cur_dir_q;
            head_ptr_d = ptr_inc(head_ptr_q);
            head_x_d   = nh_x_q;
            head_y_d   = nh_y_q;
            if (grow_q) length_d   = length_q + 7'd1;
            else        tail_ptr_d = t1_ptr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (seg_we && !i_rst) begin
            seg_x_q[seg_wa]   <= seg_wx;
            seg_y_q[seg_wa]   <= seg_wy;
            seg_dir_q[seg_wa] <= seg_wdir;
        end
    end

    assign raster_addr = {i_pos_y[8:4], i_pos_x[9:4]};

    always_ff @(posedge i_clk) begin
        if (map_we && !i_rst) map_mem[map_addr] <= map_wdata;
        valid_a_q <= map_mem[map_addr][4];
        entry_b_q <= map_mem[raster_addr];
    end

    always_comb begin
        pos_x_d    = i_pos_x;
        pos_y_d    = i_pos_y;
        in_range_d = (i_pos_x < PIX_W) && (i_pos_y < PIX_H);
    end

    assign o_snake_image = in_range_q ? entry_b_q[3:0] : 4'd0;
    assign o_hit         = in_range_q && entry_b_q[4];
    assign o_pos_x       = pos_x_q;
    assign o_pos_y       = pos_y_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_dead        = dead_q;
    assign o_collide     = collide_q;
    assign o_length      = length_q;
    assign o_head_x      = head_x_q;
    assign o_head_y      = head_y_q;

endmodule

// File: tb/tb_snake_tile_map.sv
// Directed bench for snake_tile_map: raster vector table per phase plus hand-written step sequences.
module tb_snake_tile_map;

    logic       clk = 1'b0;
    logic       i_rst, i_step, i_grow;
    logic [1:0] i_dir;
    logic [9:0] i_pos_x, i_pos_y;
    logic [3:0] o_snake_image;
    logic       o_hit, o_busy, o_dead, o_collide;
    logic [9:0] o_pos_x, o_pos_y;
    logic [6:0] o_length;
    logic [5:0] o_head_x;
    logic [4:0] o_head_y;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int phase;
        int px;
        int py;
        int hit;
        int img;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    snake_tile_map dut (
        .i_clk(clk), .i_rst(i_rst), .i_step(i_step), .i_dir(i_dir), .i_grow(i_grow),
        .i_pos_x(i_pos_x), .i_pos_y(i_pos_y),
        .o_snake_image(o_snake_image), .o_hit(o_hit), .o_pos_x(o_pos_x), .o_pos_y(o_pos_y),
        .o_busy(o_busy), .o_dead(o_dead), .o_collide(o_collide), .o_length(o_length),
        .o_head_x(o_head_x), .o_head_y(o_head_y)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int p, input int x, input int y, input int h, input int c);
        vec_t v;
        v.phase = p; v.px = x; v.py = y; v.hit = h; v.img = c;
        vt.push_back(v);
    endfunction

    task automatic run_phase(input int p);
        foreach (vt[k]) begin
            if (vt[k].phase == p) begin
                i_pos_x = 10'(vt[k].px);
                i_pos_y = 10'(vt[k].py);
                @(negedge clk);
                chk($sformatf("hit p%0d (%0d,%0d)", p, vt[k].px, vt[k].py), int'(o_hit), vt[k].hit);
                chk($sformatf("img p%0d (%0d,%0d)", p, vt[k].px, vt[k].py), int'(o_snake_image), vt[k].img);
                chk($sformatf("pos_x p%0d", p), int'(o_pos_x), vt[k].px);
            end
        end
    endtask

    task automatic do_reset(output int cycles);
        i_rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_rst  = 1'b0;
        cycles = 0;
        while (o_busy && cycles < 2000) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic do_step(input logic [1:0] d, input logic g, output int cycles);
        i_step = 1'b1;
        i_dir  = d;
        i_grow = g;
        @(negedge clk);
        i_step = 1'b0;
        i_grow = 1'b0;
        cycles = 0;
        while (o_busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic chk_head(input string name, input int x, input int y, input int len);
        chk({name, " head_x"}, int'(o_head_x), x);
        chk({name, " head_y"}, int'(o_head_y), y);
        chk({name, " length"}, int'(o_length), len);
    endtask

    initial begin
        int n;
        add(0, 160, 240, 1, 3);  add(0, 144, 240, 1, 5);  add(0, 128, 240, 1, 13);
        add(0,   0,   0, 0, 0);  add(0, 117, 250, 0, 0);  add(0, 640, 240, 0, 0);
        add(1, 179, 247, 1, 3);  add(1, 160, 240, 1, 5);  add(1, 150, 241, 1, 13);
        add(1, 128, 240, 0, 0);
        add(2, 176, 224, 1, 0);  add(2, 176, 240, 1, 8);  add(2, 165, 250, 1, 13);
        add(2, 144, 240, 0, 0);
        add(3, 192, 224, 1, 3);  add(3, 176, 224, 1, 7);  add(3, 160, 240, 1, 13);
        add(3, 176, 240, 1, 8);
        add(4, 208, 224, 1, 3);  add(4, 192, 224, 1, 5);  add(4, 160, 240, 0, 0);
        add(4, 176, 240, 1, 10); add(4, 176, 224, 1, 7);
        add(5, 208, 208, 1, 2);  add(5, 224, 208, 1, 9);  add(5, 224, 224, 1, 8);
        add(5, 208, 224, 1, 5);  add(5, 192, 224, 1, 13); add(5, 176, 224, 0, 0);
        add(5, 176, 240, 0, 0);
        add(6, 639, 240, 1, 3);  add(6, 640, 240, 0, 0);  add(6, 639, 479, 0, 0);

        i_rst = 1'b1; i_step = 1'b0; i_grow = 1'b0; i_dir = 2'd0;
        i_pos_x = 10'd100; i_pos_y = 10'd100;
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", int'(o_busy), 1);
        chk("rst dead", int'(o_dead), 0);
        chk("rst collide", int'(o_collide), 0);
        chk("rst hit", int'(o_hit), 0);
        chk("rst image", int'(o_snake_image), 0);
        chk("rst pos_x", int'(o_pos_x), 0);
        chk("rst pos_y", int'(o_pos_y), 0);
        chk_head("rst", 0, 0, 0);

        do_reset(n);
        chk("init busy cycles", n, 1203);
        chk_head("init", 10, 15, 3);
        chk("init dead", int'(o_dead), 0);
        run_phase(0);

        do_step(2'd3, 1'b0, n);
        chk("straight busy", n, 6);
        chk_head("straight", 11, 15, 3);
        run_phase(1);

        do_step(2'd0, 1'b0, n);
        chk("turn busy", n, 6);
        chk_head("turn", 11, 14, 3);
        run_phase(2);

        do_step(2'd3, 1'b1, n);
        chk("grow busy", n, 5);
        chk_head("grow", 12, 14, 4);
        run_phase(3);

        do_step(2'd2, 1'b0, n);
        chk("reverse busy", n, 6);
        chk_head("reverse", 13, 14, 4);
        run_phase(4);

        do_step(2'd3, 1'b1, n);
        chk_head("grow2", 14, 14, 5);
        do_step(2'd0, 1'b0, n);
        do_step(2'd2, 1'b0, n);
        chk_head("loop", 13, 13, 5);
        do_step(2'd1, 1'b0, n);
        chk("collide busy", n, 2);
        chk("collide pulse", int'(o_collide), 1);
        chk("dead set", int'(o_dead), 1);
        @(negedge clk);
        chk("collide single", int'(o_collide), 0);
        chk_head("collide", 13, 13, 5);
        run_phase(5);
        do_step(2'd2, 1'b0, n);
        chk("dead step busy", n, 0);
        chk_head("dead step", 13, 13, 5);

        do_reset(n);
        chk("reinit busy cycles", n, 1203);
        chk("reinit dead", int'(o_dead), 0);
        for (int s = 0; s < 29; s++) do_step(2'd3, 1'b0, n);
        chk_head("edge", 39, 15, 3);
        run_phase(6);
        do_step(2'd3, 1'b0, n);
`ifdef SNAKE_WRAP_EN
        chk("wrap dead", int'(o_dead), 0);
        chk_head("wrap", 0, 15, 3);
`else
        chk("edge busy", n, 2);
        chk("edge collide", int'(o_collide), 1);
        chk("edge dead", int'(o_dead), 1);
        chk_head("edge hold", 39, 15, 3);
`endif
        i_pos_x = 10'd640; i_pos_y = 10'd0;
        @(negedge clk);
        chk("x640 hit", int'(o_hit), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
